// File: rtl/aes128_key_expansion_if.sv
// Key-expansion request/status/read-port bundle shared between the round
// controller (master) and the AES-128 key schedule (slave).
interface aes128_key_expansion_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  modport master (
    output start, key_in, rd_idx,
    input  busy, done, keys_valid, rd_key
  );

  modport slave (
    input  start, key_in, rd_idx,
    output busy, done, keys_valid, rd_key
  );
endinterface

// File: rtl/aes128_key_expansion.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry
// bank, with a combinational read port feeding AddRoundKey.
//
// state  | meaning
// IDLE   | waiting for start; bank holds last schedule (if keys_valid)
// EXPAND | writing rk[rnd] from rk[rnd-1], rnd = 1..10
// DONE   | one-cycle completion pulse; behaves like IDLE for start
module aes128_key_expansion #(
  parameter int NR = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  aes128_key_expansion_if.slave         kx
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [3:0]   rnd;
  logic [127:0] rk [0:10];
  logic         keys_valid_q;
  logic         accept;
  logic         last_rnd;

  logic [127:0] prev_key, next_key;
  logic [31:0]  w0, w1, w2, w3, rot, sub, t;
  logic [31:0]  n0, n1, n2, n3;

  // Byte x of the table sits at bit offset (255-x)*8, i.e. {~x, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  assign accept   = (state != S_EXPAND) && kx.start;
  assign last_rnd = (rnd == LAST_RND);

  always_comb begin
    prev_key = rk[rnd - 4'd1];
    w0  = prev_key[127:96];
    w1  = prev_key[95:64];
    w2  = prev_key[63:32];
    w3  = prev_key[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    t   = sub ^ {rcon(rnd), 24'h0};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (kx.start) state_nxt = S_EXPAND;
      S_EXPAND: if (last_rnd) state_nxt = S_DONE;
      S_DONE:   state_nxt = kx.start ? S_EXPAND : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    kx.busy       = (state == S_EXPAND);
    kx.done       = (state == S_DONE);
    kx.keys_valid = keys_valid_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= 10; i++) rk[i] <= '0;
      rnd          <= '0;
      keys_valid_q <= 1'b0;
    end else if (accept) begin
      rk[0]        <= kx.key_in;
      rnd          <= 4'd1;
      keys_valid_q <= 1'b0;
    end else if (state == S_EXPAND) begin
      rk[rnd] <= next_key;
      rnd     <= rnd + 4'd1;
      if (last_rnd) keys_valid_q <= 1'b1;
    end
  end

  always_comb begin
    kx.rd_key = '0;
    if (kx.rd_idx <= 4'd10) kx.rd_key = rk[kx.rd_idx];
  end

endmodule

// File: tb/tb_aes128_key_expansion.sv
// Directed bench for the AES-128 key schedule using FIPS-197 reference vectors.
module tb_aes128_key_expansion;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  localparam logic [127:0] KEY_A     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_A_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY_A_RK2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] KEY_A_RK10= 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_B     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B_RK1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] KEY_B_RK10= 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KEY_Z     = 128'h0;
  localparam logic [127:0] KEY_Z_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] KEY_Z_RK2 = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] KEY_Z_RK10= 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] ARK_STATE = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ARK_OUT   = 128'h00102030405060708090a0b0c0d0e0f0;

  aes128_key_expansion_if kx_if ();

  aes128_key_expansion #(.NR(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kx    (kx_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_chk(input string tag, input logic [3:0] idx, input logic [127:0] exp);
    kx_if.rd_idx = idx;
    #1;
    check(tag, kx_if.rd_key, exp);
  endtask

  // Pulse start for one cycle and follow the run through its done pulse.
  task automatic run_key(input string tag, input logic [127:0] key);
    int busy_cnt;
    kx_if.key_in = key;
    kx_if.start  = 1'b1;
    tick();
    kx_if.start  = 1'b0;
    check({tag, "_kv_after_accept"}, 128'(kx_if.keys_valid), 128'(0));
    busy_cnt = 0;
    while (kx_if.busy && busy_cnt < 20) begin
      busy_cnt++;
      tick();
    end
    check({tag, "_busy_cycles"}, 128'(busy_cnt), 128'(10));
    check({tag, "_done_pulse"}, 128'(kx_if.done), 128'(1));
    check({tag, "_keys_valid"}, 128'(kx_if.keys_valid), 128'(1));
    tick();
    check({tag, "_done_drop"}, 128'(kx_if.done), 128'(0));
    check({tag, "_kv_hold"}, 128'(kx_if.keys_valid), 128'(1));
  endtask

  initial begin
    int          done_cnt;
    logic [127:0] rd_or;

    rst_n        = 1'b0;
    kx_if.start  = 1'b0;
    kx_if.key_in = '0;
    kx_if.rd_idx = 4'd0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_busy", 128'(kx_if.busy), 128'(0));
    check("rst_done", 128'(kx_if.done), 128'(0));
    check("rst_kv",   128'(kx_if.keys_valid), 128'(0));
    read_chk("rst_rk0",  4'd0,  128'h0);
    read_chk("rst_rk10", 4'd10, 128'h0);

    // FIPS-197 appendix A key
    run_key("keyA", KEY_A);
    read_chk("keyA_rk0",  4'd0,  KEY_A);
    read_chk("keyA_rk1",  4'd1,  KEY_A_RK1);
    read_chk("keyA_rk2",  4'd2,  KEY_A_RK2);
    read_chk("keyA_rk10", 4'd10, KEY_A_RK10);

    run_key("keyB", KEY_B);
    read_chk("keyB_rk0",  4'd0,  KEY_B);
    read_chk("keyB_rk1",  4'd1,  KEY_B_RK1);
    read_chk("keyB_rk10", 4'd10, KEY_B_RK10);
    kx_if.rd_idx = 4'd0;
    #1;
    check("keyB_addroundkey", kx_if.rd_key ^ ARK_STATE, ARK_OUT);

    run_key("keyZ", KEY_Z);
    read_chk("keyZ_rk1",  4'd1,  KEY_Z_RK1);
    read_chk("keyZ_rk2",  4'd2,  KEY_Z_RK2);
    read_chk("keyZ_rk10", 4'd10, KEY_Z_RK10);
    for (int i = 11; i <= 15; i++) read_chk("keyZ_oob", 4'(i), 128'h0);

    // start held high: second key must only be taken on the done cycle
    kx_if.key_in = KEY_A;
    kx_if.start  = 1'b1;
    done_cnt     = 0;
    for (int e = 1; e <= 22; e++) begin
      tick();
      if (e == 4) kx_if.key_in = KEY_Z;
      if (kx_if.done) done_cnt++;
      if (e == 11) begin
        check("hold_done_e11", 128'(kx_if.done), 128'(1));
        read_chk("hold_run1_rk1",  4'd1,  KEY_A_RK1);
        read_chk("hold_run1_rk10", 4'd10, KEY_A_RK10);
      end
      if (e == 12) begin
        check("hold_restart_kv",   128'(kx_if.keys_valid), 128'(0));
        check("hold_restart_busy", 128'(kx_if.busy), 128'(1));
        read_chk("hold_run2_rk0", 4'd0, KEY_Z);
      end
      if (e == 20) check("hold_run2_kv_mid", 128'(kx_if.keys_valid), 128'(0));
    end
    check("hold_done_count", 128'(done_cnt), 128'(2));
    check("hold_run2_kv", 128'(kx_if.keys_valid), 128'(1));
    read_chk("hold_run2_rk10", 4'd10, KEY_Z_RK10);
    kx_if.start = 1'b0;
    tick();

    // reset in the middle of an expansion
    kx_if.key_in = KEY_B;
    kx_if.start  = 1'b1;
    tick();
    kx_if.start  = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("midrst_busy_before", 128'(kx_if.busy), 128'(1));
    rst_n = 1'b0;
    tick();
    check("midrst_busy", 128'(kx_if.busy), 128'(0));
    check("midrst_done", 128'(kx_if.done), 128'(0));
    check("midrst_kv",   128'(kx_if.keys_valid), 128'(0));
    rd_or = '0;
    for (int i = 0; i <= 15; i++) begin
      kx_if.rd_idx = 4'(i);
      #1;
      rd_or = rd_or | kx_if.rd_key;
    end
    check("midrst_bank_clear", rd_or, 128'h0);
    rst_n = 1'b1;
    tick();
    run_key("post_rst", KEY_B);
    read_chk("post_rst_rk0",  4'd0,  KEY_B);
    read_chk("post_rst_rk1",  4'd1,  KEY_B_RK1);
    read_chk("post_rst_rk10", 4'd10, KEY_B_RK10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/aes128_key_expansion.md
Name: aes128_key_expansion

Overview:
- Iterative AES-128 key schedule (FIPS-197 §5.2). Takes a 128-bit cipher key and generates round keys 0..10 at one round key per clock.
- Holds all 11 round keys in an internal register bank.
- Sits directly upstream of AddRoundKey. The round controller selects a key by index and drives it onto AddRoundKey's round_key input.

Parameters:
- NR, 10, number of expansion rounds. Fixed for AES-128; any other value is unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- start  input  1  single-cycle request to expand key_in; honoured only while idle
- key_in  input  128  cipher key; key_in[127:120] is byte 0 (w0 MSB); sampled on the accepting edge only
- busy  output  1  expansion in progress
- done  output  1  one-cycle pulse; rk1..rk10 are complete
- keys_valid  output  1  bank holds a complete schedule for the last accepted key
- rd_idx  input  4  round-key select, 0..10
- rd_key  output  128  round key rk[rd_idx], combinational read; same byte order as key_in

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - busy=0, done=0, keys_valid=0.
  - All 11 bank entries=0; round counter=0; FSM=IDLE.
  - Reset has priority over every other event, including mid-expansion; a partial schedule is discarded.
- FSM states:
  - IDLE: start=1 → EXPAND. On that edge: rk0<=key_in, rnd<=1, busy<=1, keys_valid<=0.
  - EXPAND: each edge writes rk[rnd] from rk[rnd-1], then rnd<=rnd+1.
    - On the edge that writes rk10: busy<=0, done<=1, keys_valid<=1, FSM→IDLE.
- Latency:
  - Accepting edge = edge 1; rk10 is written on edge 11.
  - done is high for exactly the cycle after edge 11. busy is high for 10 cycles.
- Expansion from previous key w0..w3 (32-bit words, w0=[127:96]):
  - t = SubWord(RotWord(w3)) ^ {Rcon[rnd],24'h0}
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
  - RotWord: bytes {a,b,c,d}→{b,c,d,a}.
  - SubWord: forward AES S-box on each byte, 4 lookups, combinational, same cycle. May use the shared forward S-box.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- start while busy=1: ignored; key_in is not resampled and the expansion in flight is unaffected.
- start on the cycle done=1: FSM is already IDLE, so it is accepted. keys_valid drops on that edge and a new expansion begins.
- Read port:
  - rd_key = rk[rd_idx] for 0..10; 0 for rd_idx 11..15.
  - Reads during expansion are allowed. Entries not yet rewritten return stale data; consumers must gate reads on keys_valid.
- keys_valid stays 1 until the next accepted start or reset.
- No output is X after reset; bank writes occur only on the edges defined above.

Test Plan:
- Reset release, then key_in=2b7e151628aed2a6abf7158809cf4f3c with a 1-cycle start pulse:
  - busy high for 10 cycles, done pulses once, keys_valid=1.
  - rk1=a0fafe1788542cb123a339392a6c7605; rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
- key_in=000102030405060708090a0b0c0d0e0f:
  - rk0=key_in; rk10=13111d7fe3944a17f307a78b4d2b30c5.
  - Drive rk0 and state 00112233445566778899aabbccddeeff into AddRoundKey: output = 00102030405060708090a0b0c0d0e0f0.
- key_in=0:
  - rk1=62636363626363636263636362636363; rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
  - rd_idx=11..15 → rd_key=0.
- Start held high continuously with key_in changed mid-run:
  - The running expansion keeps the first key; exactly one done per 11 cycles.
  - A restart on the done cycle is accepted, and keys_valid=0 for that new run.
- rst_n=0 at cycle 5 of an expansion:
  - Next cycle busy=0, done=0, keys_valid=0, all rd_key reads = 0.
  - A subsequent start produces the correct full schedule.
